// File: rtl/vgroup_wb_collector_pkg.sv
// Shared vector definitions for the writeback collector: default register width,
// LMUL encodings, collector FSM states and the register-group mask helper.
package vgroup_wb_collector_pkg;

    localparam int VLEN_DEFAULT = 128;

    localparam logic [2:0] LMUL_ENC_1 = 3'b000;
    localparam logic [2:0] LMUL_ENC_2 = 3'b001;
    localparam logic [2:0] LMUL_ENC_4 = 3'b010;
    localparam logic [2:0] LMUL_ENC_8 = 3'b011;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2
    } state_e;

    // One bit per register in base..base+size-1, wrapping within the 32-entry file.
    function automatic logic [31:0] group_mask(input logic [4:0] base, input logic [3:0] size);
        logic [31:0] mask;
        mask = '0;
        for (int i = 0; i < 8; i++) begin
            if (i < int'(size)) begin
                mask[base + 5'(i)] = 1'b1;
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/vlmul_decode.sv
// Maps the 3-bit LMUL encoding to a register-group size; reserved codes act as LMUL=8.
module vlmul_decode
    import vgroup_wb_collector_pkg::*;
(
    input  logic [2:0] enc,
    output logic [3:0] size
);

    always_comb begin
        // NOTE: default assigned before the case so every path drives size and no latch is inferred.
        size = 4'd8;
        case (enc)
            LMUL_ENC_1: size = 4'd1;
            LMUL_ENC_2: size = 4'd2;
            LMUL_ENC_4: size = 4'd4;
            LMUL_ENC_8: size = 4'd8;
            default:    size = 4'd8;
        endcase
    end

endmodule

// File: rtl/vgroup_wb_collector.sv
// Collects the micro-op result beats of one grouped vector op, writes them to the
// register file in order, tracks pending registers and signals group retirement.
module vgroup_wb_collector
    import vgroup_wb_collector_pkg::*;
#(
    parameter int VLEN  = VLEN_DEFAULT,
    parameter int NVREG = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            issue_valid,
    output logic            issue_ready,
    input  logic [4:0]      issue_rdest,
    input  logic [2:0]      issue_lmul,
    input  logic            wb_valid,
    output logic            wb_ready,
    input  logic [4:0]      wb_vreg,
    input  logic [VLEN-1:0] wb_data,
    output logic            vrf_we,
    output logic [4:0]      vrf_waddr,
    output logic [VLEN-1:0] vrf_wdata,
    output logic            done_valid,
    output logic [4:0]      done_rdest,
    output logic [31:0]     busy_mask,
    output logic            err_order,
    output logic            err_align
);

    // Registers beyond the implemented file can never be marked busy.
    localparam logic [31:0] VALID_REGS = (NVREG >= 32) ? '1 : ((32'd1 << NVREG) - 32'd1);

    state_e      state_q;
    logic        live_q;
    logic [4:0]  base_q;
    logic [3:0]  size_q;
    logic [3:0]  count_q;
    logic [31:0] busy_q;

    logic [3:0]  issue_size;
    logic        issue_fire;
    logic        wb_fire;
    logic        aligned;
    logic [4:0]  exp_reg;
    logic        beat_ok;
    logic        last_beat;

    vlmul_decode u_decode (
        .enc  (issue_lmul),
        .size (issue_size)
    );

    // live_q keeps issue_ready low until the first clock edge after reset release.
    assign issue_ready = live_q && (state_q == ST_IDLE);
    assign wb_ready    = (state_q == ST_COLLECT);
    assign done_valid  = (state_q == ST_DONE);
    assign done_rdest  = base_q;
    assign busy_mask   = busy_q;

    assign issue_fire = issue_valid && issue_ready;
    assign wb_fire    = wb_valid && wb_ready;
    assign aligned    = (issue_rdest & 5'(issue_size - 4'd1)) == 5'd0;
    assign exp_reg    = base_q + {1'b0, count_q};
    assign beat_ok    = wb_fire && (wb_vreg == exp_reg);
    assign last_beat  = beat_ok && (count_q == size_q - 4'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
            state_q   <= ST_IDLE;
            live_q    <= 1'b0;
            base_q    <= 5'd0;
            size_q    <= 4'd1;
            count_q   <= 4'd0;
            busy_q    <= 32'd0;
            vrf_we    <= 1'b0;
            vrf_waddr <= 5'd0;
            vrf_wdata <= '0;
            err_order <= 1'b0;
            err_align <= 1'b0;
        end else begin
            live_q    <= 1'b1;
            vrf_we    <= 1'b0;
            err_order <= 1'b0;
            err_align <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (issue_fire) begin
                        if (aligned) begin
                            base_q  <= issue_rdest;
                            size_q  <= issue_size;
                            count_q <= 4'd0;
                            busy_q  <= busy_q | (group_mask(issue_rdest, issue_size) & VALID_REGS);
                            state_q <= ST_COLLECT;
                        end else begin
                            err_align <= 1'b1;
                        end
                    end
                end
                ST_COLLECT: begin
                    if (beat_ok) begin
                        // The busy bit drops on the same edge that raises vrf_we for it.
                        vrf_we    <= 1'b1;
                        vrf_waddr <= wb_vreg;
                        vrf_wdata <= wb_data;
                        busy_q    <= busy_q & ~(32'd1 << wb_vreg);
                        count_q   <= count_q + 4'd1;
                        if (last_beat) begin
                            state_q <= ST_DONE;
                        end
                    end else if (wb_fire) begin
                        err_order <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vgroup_wb_collector.sv
// Randomized scoreboard bench for vgroup_wb_collector against a queue-based group model.
module tb_vgroup_wb_collector;

    localparam int VLEN = 128;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            issue_valid = 1'b0;
    logic            issue_ready;
    logic [4:0]      issue_rdest = 5'd0;
    logic [2:0]      issue_lmul = 3'd0;
    logic            wb_valid = 1'b0;
    logic            wb_ready;
    logic [4:0]      wb_vreg = 5'd0;
    logic [VLEN-1:0] wb_data = '0;
    logic            vrf_we;
    logic [4:0]      vrf_waddr;
    logic [VLEN-1:0] vrf_wdata;
    logic            done_valid;
    logic [4:0]      done_rdest;
    logic [31:0]     busy_mask;
    logic            err_order;
    logic            err_align;

    vgroup_wb_collector #(.VLEN(VLEN), .NVREG(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .issue_rdest (issue_rdest),
        .issue_lmul  (issue_lmul),
        .wb_valid    (wb_valid),
        .wb_ready    (wb_ready),
        .wb_vreg     (wb_vreg),
        .wb_data     (wb_data),
        .vrf_we      (vrf_we),
        .vrf_waddr   (vrf_waddr),
        .vrf_wdata   (vrf_wdata),
        .done_valid  (done_valid),
        .done_rdest  (done_rdest),
        .busy_mask   (busy_mask),
        .err_order   (err_order),
        .err_align   (err_align)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [VLEN-1:0] act, input logic [VLEN-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: no handshake within bound (t=%0t)", name, $time);
    endtask

    // ---------------- reference model ----------------
    typedef enum {M_IDLE, M_COLLECT, M_DONE} mphase_e;
    typedef struct packed {
        logic [4:0]      addr;
        logic [VLEN-1:0] data;
    } wr_t;

    mphase_e    m_phase = M_IDLE;
    bit         m_live = 1'b0;
    logic [4:0] m_base = 5'd0;
    logic [4:0] m_pend[$];
    logic [31:0] m_busy = 32'd0;
    wr_t        exp_wr[$];
    logic [4:0] exp_done[$];
    int         exp_order = 0;
    int         exp_align = 0;
    bit         hs_issue = 1'b0;
    bit         hs_wb = 1'b0;

    function automatic int lmul_size(input logic [2:0] enc);
        return (enc >= 3'd3) ? 8 : (1 << enc);
    endfunction

    task automatic model_step();
        int sz;
        hs_issue = 1'b0;
        hs_wb = 1'b0;
        if (!rst_n) begin
            m_phase = M_IDLE;
            m_live = 1'b0;
            m_pend.delete();
            m_busy = 32'd0;
        end else begin
            case (m_phase)
                M_IDLE: if (m_live && issue_valid) begin
                    hs_issue = 1'b1;
                    sz = lmul_size(issue_lmul);
                    if (int'(issue_rdest) % sz == 0) begin
                        m_base = issue_rdest;
                        for (int i = 0; i < sz; i++) begin
                            m_pend.push_back(5'((int'(issue_rdest) + i) % 32));
                            m_busy[(int'(issue_rdest) + i) % 32] = 1'b1;
                        end
                        m_phase = M_COLLECT;
                    end else begin
                        exp_align++;
                    end
                end
                M_COLLECT: if (wb_valid) begin
                    hs_wb = 1'b1;
                    if (wb_vreg == m_pend[0]) begin
                        void'(m_pend.pop_front());
                        exp_wr.push_back('{addr: wb_vreg, data: wb_data});
                        m_busy[wb_vreg] = 1'b0;
                        if (m_pend.size() == 0) begin
                            exp_done.push_back(m_base);
                            m_phase = M_DONE;
                        end
                    end else begin
                        exp_order++;
                    end
                end
                M_DONE: m_phase = M_IDLE;
                default: m_phase = M_IDLE;
            endcase
            m_live = 1'b1;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // ---------------- monitor / scoreboard ----------------
    task automatic monitor_step();
        wr_t        w;
        logic [4:0] d;
        if (!rst_n) begin
            check("reset_outputs",
                  VLEN'({issue_ready, wb_ready, vrf_we, vrf_waddr, done_valid, done_rdest,
                         err_order, err_align, busy_mask}), '0);
            check("reset_wdata", vrf_wdata, '0);
            exp_wr.delete();
            exp_done.delete();
            exp_order = 0;
            exp_align = 0;
        end else begin
            check("issue_ready", VLEN'(issue_ready), VLEN'(m_phase == M_IDLE && m_live));
            check("wb_ready", VLEN'(wb_ready), VLEN'(m_phase == M_COLLECT));
            check("busy_mask", VLEN'(busy_mask), VLEN'(m_busy));
            check("vrf_we", VLEN'(vrf_we), VLEN'(exp_wr.size() != 0));
            if (vrf_we && exp_wr.size() != 0) begin
                w = exp_wr.pop_front();
                check("vrf_waddr", VLEN'(vrf_waddr), VLEN'(w.addr));
                check("vrf_wdata", vrf_wdata, w.data);
            end
            check("done_valid", VLEN'(done_valid), VLEN'(exp_done.size() != 0));
            if (done_valid && exp_done.size() != 0) begin
                d = exp_done.pop_front();
                check("done_rdest", VLEN'(done_rdest), VLEN'(d));
            end
            check("err_order", VLEN'(err_order), VLEN'(exp_order > 0));
            check("err_align", VLEN'(err_align), VLEN'(exp_align > 0));
            exp_order = 0;
            exp_align = 0;
        end
    endtask

    initial forever begin
        @(negedge clk);
        monitor_step();
    end

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    function automatic logic [VLEN-1:0] rand_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic wait_issue();
        for (int k = 0; k < 40; k++) begin
            tick();
            if (hs_issue) return;
        end
        timeout_fail("issue_handshake");
    endtask

    task automatic wait_wb();
        for (int k = 0; k < 40; k++) begin
            tick();
            if (hs_wb) return;
        end
        timeout_fail("wb_handshake");
    endtask

    task automatic do_issue(input logic [4:0] rd, input logic [2:0] enc);
        issue_valid = 1'b1;
        issue_rdest = rd;
        issue_lmul = enc;
        wait_issue();
        issue_valid = 1'b0;
        issue_rdest = 5'($urandom);
        issue_lmul = 3'($urandom);
    endtask

    task automatic do_beat(input logic [4:0] v, input logic [VLEN-1:0] d);
        wb_valid = 1'b1;
        wb_vreg = v;
        wb_data = d;
        wait_wb();
        wb_valid = 1'b0;
        wb_vreg = 5'($urandom);
        wb_data = '0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int         n;
        logic       rb;
        int         sz;
        logic [4:0] rd;
        logic [2:0] enc;

        idle(2);
        rst_n = 1'b1;
        idle(2);

        // LMUL=1 single beat
        do_issue(5'd5, 3'b000);
        check("busy_bit5_set", VLEN'(busy_mask), VLEN'(32'h0000_0020));
        do_beat(5'd5, rand_data());
        idle(2);

        // LMUL=8 with wb_valid gaps
        do_issue(5'd8, 3'b011);
        check("busy_lmul8", VLEN'(busy_mask), VLEN'(32'h0000_FF00));
        for (int i = 0; i < 8; i++) begin
            idle($urandom_range(0, 2));
            do_beat(5'(8 + i), rand_data());
        end
        idle(2);

        // LMUL=4 with an out-of-order beat
        do_issue(5'd4, 3'b010);
        do_beat(5'd4, rand_data());
        do_beat(5'd6, rand_data());
        do_beat(5'd5, rand_data());
        do_beat(5'd6, rand_data());
        do_beat(5'd7, rand_data());
        idle(2);

        // misaligned base
        do_issue(5'd3, 3'b001);
        idle(3);

        // reset mid-group
        do_issue(5'd28, 3'b010);
        do_beat(5'd28, rand_data());
        do_beat(5'd29, rand_data());
        idle(1);
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(1);
        do_issue(5'd0, 3'b000);
        do_beat(5'd0, rand_data());
        idle(2);

        // issue_valid held through DONE
        do_issue(5'd16, 3'b001);
        do_beat(5'd16, rand_data());
        issue_valid = 1'b1;
        issue_rdest = 5'd30;
        issue_lmul = 3'b001;
        wb_valid = 1'b1;
        wb_vreg = 5'd17;
        wb_data = rand_data();
        wait_wb();
        wb_valid = 1'b0;
        n = 0;
        for (int k = 0; k < 10; k++) begin
            rb = issue_ready;
            tick();
            n++;
            if (rb) break;
        end
        check("issue_gap_after_last_beat", VLEN'(n), VLEN'(2));
        issue_valid = 1'b0;
        do_beat(5'd30, rand_data());
        do_beat(5'd31, rand_data());
        idle(2);

        // randomized groups
        for (int g = 0; g < 40; g++) begin
            enc = 3'($urandom_range(0, 7));
            sz = lmul_size(enc);
            rd = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 3) != 0) rd = 5'(int'(rd) - int'(rd) % sz);
            do_issue(rd, enc);
            if (int'(rd) % sz == 0) begin
                for (int i = 0; i < sz; i++) begin
                    idle($urandom_range(0, 2));
                    if ($urandom_range(0, 4) == 0)
                        do_beat(5'(int'(rd) + i + $urandom_range(1, 6)), rand_data());
                    do_beat(5'(int'(rd) + i), rand_data());
                end
            end
            idle($urandom_range(0, 3));
        end

        idle(3);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vgroup_wb_collector.md
VGROUP_WB_COLLECTOR -- requirements
Module: vgroup_wb_collector

Interface
REQ-001 SHALL have parameter VLEN, default 128, giving the vector register width in bits.
REQ-002 SHALL have parameter NVREG, default 32, giving the vector register count; register indices are 5 bits.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port issue_valid, input, 1 bit: a grouped vector op is announced.
REQ-006 SHALL have port issue_ready, output, 1 bit: the collector accepts an announcement.
REQ-007 SHALL have port issue_rdest, input, 5 bits: the group base destination register.
REQ-008 SHALL have port issue_lmul, input, 3 bits: encoded LMUL (000=1, 001=2, 010=4, 011=8, others=8).
REQ-009 SHALL have port wb_valid, input, 1 bit: a micro-op result beat is present.
REQ-010 SHALL have port wb_ready, output, 1 bit: the collector accepts the beat.
REQ-011 SHALL have port wb_vreg, input, 5 bits: the micro-op destination register.
REQ-012 SHALL have port wb_data, input, VLEN bits: the micro-op result.
REQ-013 SHALL have port vrf_we, output, 1 bit: register file write enable.
REQ-014 SHALL have port vrf_waddr, output, 5 bits: register file write address.
REQ-015 SHALL have port vrf_wdata, output, VLEN bits: register file write data.
REQ-016 SHALL have port done_valid, output, 1 bit: one-cycle pulse when the whole group has retired.
REQ-017 SHALL have port done_rdest, output, 5 bits: base register of the retired group.
REQ-018 SHALL have port busy_mask, output, 32 bits: registers with pending writes, used for hazard checks.
REQ-019 SHALL have port err_order, output, 1 bit: one-cycle pulse when an out-of-order or foreign beat arrives.
REQ-020 SHALL have port err_align, output, 1 bit: one-cycle pulse when the announced base is not aligned to LMUL.

Function
REQ-021 SHALL implement FSM states IDLE, COLLECT and DONE; only one group is outstanding at a time.
REQ-022 SHALL drive issue_ready=1 only in IDLE, and wb_ready=1 only in COLLECT.
REQ-023 SHALL, on an IDLE issue handshake with issue_rdest mod LMUL = 0, capture base and decoded LMUL, clear the beat count, set busy_mask bits base..base+LMUL-1, and enter COLLECT.
REQ-024 SHALL, on an IDLE issue handshake with a misaligned base, pulse err_align the next cycle, capture nothing, and remain in IDLE.
REQ-025 SHALL treat the expected register as (base+count) mod 32, a 5-bit wrap.
REQ-026 SHALL, on a COLLECT wb handshake with wb_vreg equal to the expected register, register the beat so that vrf_we=1, vrf_waddr=wb_vreg and vrf_wdata=wb_data appear exactly one cycle later, then increment count.
REQ-027 SHALL clear the busy_mask bit for a register in the same cycle its vrf_we is asserted.
REQ-028 SHALL, on a mismatched wb_vreg, still complete the handshake, drop the beat, pulse err_order the next cycle, and leave count unchanged.
REQ-029 SHALL, when the accepted beat is the last one (count = LMUL-1), enter DONE; in DONE, done_valid=1 and done_rdest=base, coincident with the final vrf_we.
REQ-030 SHALL always go from DONE to IDLE after one cycle, so issue_ready returns two cycles after the last beat handshake.
REQ-031 SHALL hold vrf_we, done_valid, err_order and err_align at 0 in every cycle other than those specified above.

Reset
REQ-032 SHALL, on rst_n low at any time, including mid-group, go immediately to IDLE and force issue_ready=0, wb_ready=0, vrf_we=0, vrf_waddr=0, vrf_wdata=0, done_valid=0, done_rdest=0, busy_mask=0, err_order=0, err_align=0, and count=0.
REQ-033 SHALL drop any partially collected group on reset without a done pulse; issue_ready=1 on the first clock edge after rst_n rises.

Structure
REQ-034 SHALL place the FSM state enum, the LMUL encoding constants and the VLEN default in the shared vector package.
REQ-035 SHALL instantiate one sub-module, vlmul_decode, which maps the 3-bit encoding to a 4-bit group size.

Verification
REQ-036 SHALL cover: LMUL=1, rdest=5, one beat (vreg 5) -> vrf_we@5 and done_valid/done_rdest=5 in the same cycle; busy_mask bit5 set then cleared.
REQ-037 SHALL cover: LMUL=8, rdest=8, beats vreg 8..15 with wb_valid gaps -> eight writes in order, a single done_valid, busy_mask 0x0000FF00 draining to 0.
REQ-038 SHALL cover: LMUL=4, rdest=4, beats 4, 6, 5, 6, 7 -> err_order on the first beat 6, writes 4, 5, 6, 7, and done_valid after beat 7.
REQ-039 SHALL cover: LMUL=2, rdest=3 -> err_align pulse, collector stays IDLE, busy_mask=0.
REQ-040 SHALL cover: LMUL=4, rdest=28, reset asserted after two beats -> all outputs 0, no done_valid, and a new issue is accepted after release.
REQ-041 SHALL cover: issue_valid held high through DONE -> no issue handshake until IDLE, two cycles after the last beat.
